// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller.
//   - address split constants (8-byte line, index above the offset, tag on top)
//   - controller state encoding and memory bus command encoding
//   - request latch record
package dcache_pkg;

  localparam int OFFSET_W          = 3;
  localparam int BLOCK_W           = 64;
  localparam int DCACHE_INDEX_SIZE = 5;
  localparam int DCACHE_TAG_SIZE   = 64 - DCACHE_INDEX_SIZE - OFFSET_W;
  localparam int LINE_W            = 64 - OFFSET_W;
  localparam int INDEX_LSB         = OFFSET_W;
  localparam int TAG_LSB           = OFFSET_W + DCACHE_INDEX_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL_REQ,
    WAIT_FILL,
    RESP
  } dcache_ctrl_state_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

  // Request as latched in IDLE; line is the byte address without the offset.
  typedef struct packed {
    logic               is_store;
    logic [LINE_W-1:0]  line;
    logic [BLOCK_W-1:0] data;
    logic [3:0]         id;
  } dcache_req_t;

endpackage

// File: rtl/dcache_controller.sv
// Blocking data-cache controller between the LSQ and the cache array.
// One request in flight; the LSQ is stalled via lsq_req_ready outside IDLE.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   lsq_req_*                    : request in (valid/is_store/addr/data/id), ready out
//   lsq_resp_*                   : one-cycle completion (valid/id/data)
//   index_out, tag_out           : address split of the latched request to the array
//   read_enable, write_enable    : array strobes (load / store)
//   write_data_out               : latched store data to the array
//   store_to_memory_enable       : clears victim dirty bit when the writeback is accepted
//   data_is_valid/dirty/miss     : array lookup result (same cycle as strobe)
//   data_out, victim_tag         : array read data (registered), replacement way tag
//   proc2mem_command/addr        : memory request (NONE/LOAD/STORE, line address)
//   mem2proc_response/tag        : memory grant tag / data-return tag
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int INDEX_W = DCACHE_INDEX_SIZE,
  parameter int TAG_W   = DCACHE_TAG_SIZE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               lsq_req_valid,
  input  logic               lsq_req_is_store,
  input  logic [63:0]        lsq_req_addr,
  input  logic [63:0]        lsq_req_data,
  input  logic [3:0]         lsq_req_id,
  output logic               lsq_req_ready,
  output logic               lsq_resp_valid,
  output logic [3:0]         lsq_resp_id,
  output logic [63:0]        lsq_resp_data,
  output logic [INDEX_W-1:0] index_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               read_enable,
  output logic               write_enable,
  output logic [63:0]        write_data_out,
  output logic               store_to_memory_enable,
  input  logic               data_is_valid,
  input  logic               data_is_dirty,
  input  logic               data_is_miss,
  input  logic [63:0]        data_out,
  input  logic [TAG_W-1:0]   victim_tag,
  output logic [1:0]         proc2mem_command,
  output logic [63:0]        proc2mem_addr,
  input  logic [3:0]         mem2proc_response,
  input  logic [3:0]         mem2proc_tag
);

  dcache_ctrl_state_t state, state_n;
  dcache_req_t        req_q;
  logic [TAG_W-1:0]   victim_q;
  logic [3:0]         pend_tag;
  bus_cmd_t           cmd;
  logic               hit;
  logic               granted;
  logic               unused_offset;

  // Offset bits select a byte inside the single-word line; nothing uses them.
  assign unused_offset = ^lsq_req_addr[OFFSET_W-1:0];

  assign hit     = data_is_valid && !data_is_miss;
  assign granted = (mem2proc_response != 4'd0);

  assign index_out        = req_q.line[INDEX_W-1:0];
  assign tag_out          = req_q.line[INDEX_W +: TAG_W];
  assign write_data_out   = req_q.data;
  assign proc2mem_command = cmd;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Request latch, victim tag and outstanding fill tag
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q    <= '0;
      victim_q <= '0;
      pend_tag <= '0;
    end else begin
      if (state == IDLE && lsq_req_valid)
        req_q <= '{is_store: lsq_req_is_store, line: lsq_req_addr[63:OFFSET_W],
                   data: lsq_req_data, id: lsq_req_id};
      if (state == LOOKUP && !hit && data_is_dirty)
        victim_q <= victim_tag;
      // pend_tag only latches at the grant, so a return in the grant cycle can never match.
      if (state == FILL_REQ && granted)
        pend_tag <= mem2proc_response;
      if (state == RESP)
        pend_tag <= '0;
    end
  end

  // Next state
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (lsq_req_valid) state_n = LOOKUP;
      LOOKUP: begin
        if (hit)                state_n = RESP;
        else if (data_is_dirty) state_n = WRITEBACK;
        else                    state_n = FILL_REQ;
      end
      // After the writeback the victim is clean, so a second lookup heads to FILL_REQ.
      WRITEBACK: if (granted) state_n = LOOKUP;
      FILL_REQ:  if (granted) state_n = WAIT_FILL;
      WAIT_FILL: if (pend_tag != 4'd0 && mem2proc_tag == pend_tag) state_n = RESP;
      RESP:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    lsq_req_ready          = 1'b0;
    lsq_resp_valid         = 1'b0;
    lsq_resp_id            = '0;
    lsq_resp_data          = '0;
    read_enable            = 1'b0;
    write_enable           = 1'b0;
    store_to_memory_enable = 1'b0;
    cmd                    = BUS_NONE;
    proc2mem_addr          = '0;
    unique case (state)
      IDLE: lsq_req_ready = 1'b1;
      LOOKUP: begin
        read_enable  = !req_q.is_store;
        write_enable = req_q.is_store;
      end
      WRITEBACK: begin
        cmd                    = BUS_STORE;
        proc2mem_addr          = {victim_q, index_out, {OFFSET_W{1'b0}}};
        store_to_memory_enable = granted;
      end
      // The strobe is repeated so the array records the grant tag for the fill.
      FILL_REQ: begin
        cmd           = BUS_LOAD;
        proc2mem_addr = {req_q.line, {OFFSET_W{1'b0}}};
        read_enable   = !req_q.is_store;
        write_enable  = req_q.is_store;
      end
      RESP: begin
        lsq_resp_valid = 1'b1;
        lsq_resp_id    = req_q.id;
        lsq_resp_data  = req_q.is_store ? 64'd0 : data_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller. The cache array and memory are
// behavioural environment models; expected LSQ results come from a flat
// word-addressed memory that loads read and stores write.
module tb_dcache_controller;
  import dcache_pkg::*;

  localparam int IW = DCACHE_INDEX_SIZE;
  localparam int TW = DCACHE_TAG_SIZE;
  localparam int NL = 1 << IW;

  logic          clock = 1'b0;
  logic          reset;
  logic          lsq_req_valid, lsq_req_is_store;
  logic [63:0]   lsq_req_addr, lsq_req_data;
  logic [3:0]    lsq_req_id;
  logic          lsq_req_ready, lsq_resp_valid;
  logic [3:0]    lsq_resp_id;
  logic [63:0]   lsq_resp_data;
  logic [IW-1:0] index_out;
  logic [TW-1:0] tag_out;
  logic          read_enable, write_enable, store_to_memory_enable;
  logic [63:0]   write_data_out;
  logic          data_is_valid, data_is_dirty, data_is_miss;
  logic [63:0]   data_out;
  logic [TW-1:0] victim_tag;
  logic [1:0]    proc2mem_command;
  logic [63:0]   proc2mem_addr;
  logic [3:0]    mem2proc_response, mem2proc_tag;

  always #5 clock = ~clock;

  dcache_controller #(.INDEX_W(IW), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .lsq_req_valid(lsq_req_valid), .lsq_req_is_store(lsq_req_is_store),
    .lsq_req_addr(lsq_req_addr), .lsq_req_data(lsq_req_data), .lsq_req_id(lsq_req_id),
    .lsq_req_ready(lsq_req_ready), .lsq_resp_valid(lsq_resp_valid),
    .lsq_resp_id(lsq_resp_id), .lsq_resp_data(lsq_resp_data),
    .index_out(index_out), .tag_out(tag_out),
    .read_enable(read_enable), .write_enable(write_enable),
    .write_data_out(write_data_out), .store_to_memory_enable(store_to_memory_enable),
    .data_is_valid(data_is_valid), .data_is_dirty(data_is_dirty), .data_is_miss(data_is_miss),
    .data_out(data_out), .victim_tag(victim_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line key for the small address space the bench uses (tag < 32, index < 8).
  function automatic logic [7:0] key(input logic [TW-1:0] tg, input logic [IW-1:0] ix);
    return {tg[4:0], ix[2:0]};
  endfunction

  function automatic logic [63:0] init_val(input logic [7:0] k);
    return {32'hC0DE_0000 + 32'(k), ~(32'(k) * 32'h0101_0101)};
  endfunction

  // ---------------- reference: flat memory ----------------
  logic [63:0] ref_mem [logic [7:0]];

  function automatic logic [63:0] ref_rd(input logic [7:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
  endfunction

  // ---------------- environment: cache array + memory ----------------
  logic          a_valid [NL];
  logic          a_dirty [NL];
  logic [TW-1:0] a_tag   [NL];
  logic [63:0]   a_data  [NL];
  logic [63:0]   backing [256];

  logic          arr_clr = 1'b0;
  logic          pre_en  = 1'b0, pre_dirty = 1'b0;
  logic [IW-1:0] pre_idx = '0;
  logic [TW-1:0] pre_tag = '0;
  logic [63:0]   pre_data = '0;

  logic          ap_valid = 1'b0, ap_store = 1'b0;
  logic [3:0]    ap_tag = '0;
  logic [IW-1:0] ap_idx = '0;
  logic [TW-1:0] ap_tagv = '0;
  logic [63:0]   ap_wdata = '0;

  typedef struct {
    logic [3:0] tag;
    int         due;
  } ret_t;
  ret_t rq[$];

  int          cyc = 0, refused = 0, busy_cfg = 0, ret_delay = 0, stray_at_cyc = -1;
  logic [3:0]  next_tag = 4'd1;
  int          n_load = 0, n_store = 0, n_stme = 0, n_fill = 0, n_load_cyc = 0, n_stray = 0;
  logic [63:0] last_store_addr = '0;

  always_comb begin
    data_is_valid = 1'b0;
    data_is_dirty = 1'b0;
    data_is_miss  = 1'b0;
    victim_tag    = '0;
    if (read_enable || write_enable) begin
      data_is_valid = a_valid[index_out] && (a_tag[index_out] == tag_out);
      data_is_miss  = !data_is_valid;
      data_is_dirty = !data_is_valid && a_valid[index_out] && a_dirty[index_out];
      victim_tag    = a_tag[index_out];
    end
  end

  always_comb begin
    mem2proc_response = 4'd0;
    if (proc2mem_command != 2'd0 && refused >= busy_cfg) mem2proc_response = next_tag;
  end

  always @(posedge clock) begin
    int d;
    cyc <= cyc + 1;
    if (proc2mem_command == 2'd1) n_load_cyc <= n_load_cyc + 1;
    if (proc2mem_command == 2'd0)          refused <= 0;
    else if (mem2proc_response == 4'd0)    refused <= refused + 1;
    else                                   refused <= 0;
    if (proc2mem_command != 2'd0 && mem2proc_response != 4'd0) begin
      next_tag <= (next_tag == 4'd8) ? 4'd1 : next_tag + 4'd1;
      if (proc2mem_command == 2'd2) begin
        backing[key(proc2mem_addr[63:IW+3], proc2mem_addr[IW+2:3])] <= a_data[index_out];
        n_store         <= n_store + 1;
        last_store_addr <= proc2mem_addr;
      end else begin
        n_load <= n_load + 1;
        d = (ret_delay > 0) ? ret_delay : int'($urandom_range(1, 4));
        rq.push_back('{tag: mem2proc_response, due: cyc + 1 + d});
      end
    end
    if (read_enable || write_enable) begin
      if (data_is_valid) begin
        if (read_enable) data_out <= a_data[index_out];
        else begin
          a_data[index_out]  <= write_data_out;
          a_dirty[index_out] <= 1'b1;
        end
      end else if (mem2proc_response != 4'd0) begin
        ap_valid <= 1'b1;
        ap_tag   <= mem2proc_response;
        ap_idx   <= index_out;
        ap_tagv  <= tag_out;
        ap_store <= write_enable;
        ap_wdata <= write_data_out;
      end
    end
    if (store_to_memory_enable) begin
      a_dirty[index_out] <= 1'b0;
      n_stme <= n_stme + 1;
    end
    if (ap_valid && mem2proc_tag != 4'd0 && mem2proc_tag == ap_tag) begin
      ap_valid        <= 1'b0;
      n_fill          <= n_fill + 1;
      a_valid[ap_idx] <= 1'b1;
      a_tag[ap_idx]   <= ap_tagv;
      a_dirty[ap_idx] <= ap_store;
      a_data[ap_idx]  <= ap_store ? ap_wdata : backing[key(ap_tagv, ap_idx)];
      data_out        <= ap_store ? ap_wdata : backing[key(ap_tagv, ap_idx)];
    end
    if (pre_en) begin
      a_valid[pre_idx] <= 1'b1;
      a_tag[pre_idx]   <= pre_tag;
      a_data[pre_idx]  <= pre_data;
      a_dirty[pre_idx] <= pre_dirty;
      if (!pre_dirty) backing[key(pre_tag, pre_idx)] <= pre_data;
    end
    if (arr_clr) begin
      for (int i = 0; i < NL; i++) begin
        a_valid[i] <= 1'b0;
        a_dirty[i] <= 1'b0;
      end
      for (int i = 0; i < 256; i++) backing[i] <= init_val(8'(i));
    end
    if (reset) ap_valid <= 1'b0;
  end

  always @(negedge clock) begin
    mem2proc_tag <= 4'd0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem2proc_tag <= rq[0].tag;
      void'(rq.pop_front());
    end else if (cyc == stray_at_cyc) begin
      mem2proc_tag <= 4'd9;
      n_stray      <= n_stray + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input logic [IW-1:0] ix, input logic [TW-1:0] tg,
                         input logic [63:0] dat, input logic dirty);
    pre_en = 1'b1; pre_idx = ix; pre_tag = tg; pre_data = dat; pre_dirty = dirty;
    ref_mem[key(tg, ix)] = dat;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_ready"}, lsq_req_ready, 1);
    chk({p, "_resp_valid"}, lsq_resp_valid, 0);
    chk({p, "_resp_id"}, lsq_resp_id, 0);
    chk({p, "_resp_data"}, lsq_resp_data, 0);
    chk({p, "_rd"}, read_enable, 0);
    chk({p, "_wr"}, write_enable, 0);
    chk({p, "_stme"}, store_to_memory_enable, 0);
    chk({p, "_cmd"}, proc2mem_command, 0);
    chk({p, "_maddr"}, proc2mem_addr, 0);
    chk({p, "_index"}, index_out, 0);
    chk({p, "_tag"}, tag_out, 0);
    chk({p, "_wdata"}, write_data_out, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after RESP.
  task automatic run_req(input bit st, input logic [TW-1:0] tg, input logic [IW-1:0] ix,
                         input logic [63:0] dat, input logic [3:0] id,
                         output int lat, output int fills);
    logic [63:0] exp;
    logic [2:0]  off;
    int          f0;
    exp = st ? 64'd0 : ref_rd(key(tg, ix));
    if (st) ref_mem[key(tg, ix)] = dat;
    off = 3'($urandom);
    lsq_req_valid = 1'b1; lsq_req_is_store = st; lsq_req_addr = {tg, ix, off};
    lsq_req_data = dat; lsq_req_id = id;
    chk("req_ready", lsq_req_ready, 1);
    f0 = n_fill;
    @(posedge clock);
    @(negedge clock);
    lsq_req_valid = 1'b0;
    lsq_req_data  = $urandom;
    lat = 1;
    while (!lsq_resp_valid && lat < 60) begin
      chk("ready_low", lsq_req_ready, 0);
      chk("strobe_excl", read_enable & write_enable, 0);
      @(negedge clock);
      lat++;
    end
    chk("resp_seen", lsq_resp_valid, 1);
    chk("resp_id", lsq_resp_id, id);
    chk("resp_data", lsq_resp_data, exp);
    fills = n_fill - f0;
    @(negedge clock);
  endtask

  initial begin
    int lat, fills, n0, s0, m0, k;
    reset = 1'b1; lsq_req_valid = 1'b0; lsq_req_is_store = 1'b0;
    lsq_req_addr = '0; lsq_req_data = '0; lsq_req_id = '0;
    arr_clr = 1'b1;
    repeat (3) @(negedge clock);
    arr_clr = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Load hit: two-cycle latency.
    preload(5, 56'h12, 64'hDEAD, 1'b0);
    run_req(1'b0, 56'h12, 5, 64'h0, 4'd3, lat, fills);
    chk("hit_latency", lat, 2);
    chk("hit_no_fill", fills, 0);

    // Clean load miss: a single LOAD, one fill.
    ret_delay = 4;
    n0 = n_load;
    run_req(1'b0, 56'h0A, 2, 64'h0, 4'd5, lat, fills);
    chk("clean_miss_loads", n_load - n0, 1);
    chk("clean_miss_fill", fills, 1);

    // Store miss over a dirty victim.
    preload(6, 56'h7, 64'hCAFE_F00D, 1'b1);
    s0 = n_store; m0 = n_stme; n0 = n_load;
    run_req(1'b1, 56'h3, 6, 64'h1234_5678_9ABC_DEF0, 4'd7, lat, fills);
    chk("wb_count", n_store - s0, 1);
    chk("wb_addr", last_store_addr, {56'h7, 5'd6, 3'b000});
    chk("wb_dirty_clear", n_stme - m0, 1);
    chk("wb_then_fill", n_load - n0, 1);
    run_req(1'b0, 56'h3, 6, 64'h0, 4'd8, lat, fills);
    chk("merged_hit_latency", lat, 2);
    run_req(1'b0, 56'h7, 6, 64'h0, 4'd9, lat, fills);

    // Memory busy for three cycles in FILL_REQ.
    busy_cfg = 3;
    n0 = n_load_cyc;
    run_req(1'b0, 56'h0B, 4, 64'h0, 4'd10, lat, fills);
    chk("busy_load_cycles", n_load_cyc - n0, 4);
    busy_cfg = 0;

    // Stray return tag while waiting for the fill.
    ret_delay    = 5;
    stray_at_cyc = cyc + 4;
    n0 = n_stray;
    run_req(1'b0, 56'h0C, 1, 64'h0, 4'd11, lat, fills);
    chk("stray_sent", n_stray - n0, 1);
    chk("stray_fill_first", fills, 1);

    // Reset while waiting for a fill; the late return must be ignored.
    ret_delay = 6;
    lsq_req_valid = 1'b1; lsq_req_is_store = 1'b0; lsq_req_addr = {56'h15, 5'd7, 3'b000};
    lsq_req_id = 4'd12;
    @(posedge clock);
    @(negedge clock);
    lsq_req_valid = 1'b0;
    n0 = n_load; k = 0;
    while (n_load == n0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("rst_fill_granted", n_load - n0, 1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (12) begin
      @(negedge clock);
      chk("late_tag_ignored", lsq_resp_valid, 0);
    end

    // Random traffic over a small conflicting address set.
    ret_delay = 0;
    for (int i = 0; i < 150; i++) begin
      busy_cfg = $urandom_range(0, 2);
      run_req(1'($urandom), TW'($urandom_range(1, 4)), IW'($urandom_range(0, 3)),
              {$urandom, $urandom}, 4'($urandom), lat, fills);
      if (fills == 0) chk("rand_hit_latency", lat, 2);
    end
    busy_cfg = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
